// File: rtl/dcache_miss_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dcache_miss_arbiter
//
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS dcache miss/eviction
// ports. Each channel runs a small FSM (IDLE -> READ_WAIT/WRITE_WAIT -> RELAY)
// and remembers which consumer owns it until that consumer drops its valid.
// Write-backs win over fills when a consumer raises both valids.
//
// Configuration macro: DCACHE_ARB_ROUND_ROBIN_EN
//   defined   : the search for a pending consumer starts at a round-robin
//               pointer that moves past the last granted consumer.
//   undefined : the search always starts at consumer 0 (fixed priority).
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   cons_read_valid/address    per-consumer fill requests (in)
//   cons_read_ready/data       per-consumer fill completion + data (out)
//   cons_write_valid/address/data  per-consumer write-back requests (in)
//   cons_write_ready           per-consumer write-back completion (out)
//   mem_read_valid/address     per-channel read request (out)
//   mem_read_ready/data        per-channel read response (in)
//   mem_write_valid/address/data   per-channel write request (out)
//   mem_write_ready            per-channel write acceptance (in)
// -----------------------------------------------------------------------------
module dcache_miss_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           cons_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] cons_read_address,
  output logic [NUM_CONSUMERS-1:0]           cons_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_read_data,
  input  logic [NUM_CONSUMERS-1:0]           cons_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] cons_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_write_data,
  output logic [NUM_CONSUMERS-1:0]           cons_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELAY      = 2'd3
  } ch_state_t;

  ch_state_t             state      [NUM_CHANNELS];
  logic [IDX_BITS-1:0]   owner      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] relay_write;

  logic [NUM_CONSUMERS-1:0] owned;
  logic [NUM_CONSUMERS-1:0] pending;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CHANNELS-1:0]  grant;
  logic [IDX_BITS-1:0]      grant_idx  [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      search_base;
  logic [IDX_BITS-1:0]      cand;
  logic                     take;

  // (base + offset) mod NUM_CONSUMERS; offset is always below NUM_CONSUMERS
  function automatic logic [IDX_BITS-1:0] wrap_add(input logic [IDX_BITS-1:0] base,
                                                   input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= NUM_CONSUMERS) ? IDX_BITS'(sum - NUM_CONSUMERS) : IDX_BITS'(sum);
  endfunction

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] last_grant;
  logic                any_grant;

  assign search_base = rr_ptr;

  // Round-robin pointer moves just past the highest-scanned grant of the cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= wrap_add(last_grant, 1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  assign search_base = '0;
`endif

  // A consumer is busy while a channel holds it or its ready is still shown
  always_comb begin
    owned = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      owned[owner[c]] = owned[owner[c]] | (state[c] != ST_IDLE);
    end
    pending = (cons_read_valid | cons_write_valid) & ~owned
              & ~cons_read_ready & ~cons_write_ready;
  end

  // Idle channels, lowest index first, each take the first unclaimed pending
  // consumer found searching upward (with wrap) from search_base
  always_comb begin
    claimed = '0;
    grant   = '0;
    cand    = '0;
    take    = 1'b0;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
    any_grant  = 1'b0;
    last_grant = '0;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_idx[c] = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        cand = wrap_add(search_base, k);
        take = (state[c] == ST_IDLE) && !grant[c] && pending[cand] && !claimed[cand];
        grant_idx[c]  = take ? cand : grant_idx[c];
        claimed[cand] = claimed[cand] | take;
        grant[c]      = grant[c] | take;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
        last_grant = take ? cand : last_grant;
        any_grant  = any_grant | take;
`endif
      end
    end
  end

  // Channel FSMs together with every registered output they drive
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= ST_IDLE;
        owner[c] <= '0;
      end
      relay_write       <= '0;
      mem_read_valid    <= '0;
      mem_read_address  <= '0;
      mem_write_valid   <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      cons_read_ready   <= '0;
      cons_read_data    <= '0;
      cons_write_ready  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          ST_IDLE: begin
            if (grant[c]) begin
              owner[c] <= grant_idx[c];
              // write-back goes first when the consumer asks for both
              if (cons_write_valid[grant_idx[c]]) begin
                mem_write_valid[c] <= 1'b1;
                mem_write_address[c*ADDR_BITS +: ADDR_BITS] <=
                  cons_write_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                mem_write_data[c*DATA_BITS +: DATA_BITS] <=
                  cons_write_data[grant_idx[c]*DATA_BITS +: DATA_BITS];
                state[c] <= ST_WRITE_WAIT;
              end else begin
                mem_read_valid[c] <= 1'b1;
                mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                  cons_read_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                state[c] <= ST_READ_WAIT;
              end
            end else begin
              state[c] <= ST_IDLE;
            end
          end
          ST_READ_WAIT: begin
            // consumer valid is ignored here: a started access always completes
            if (mem_read_ready[c]) begin
              mem_read_valid[c]        <= 1'b0;
              cons_read_ready[owner[c]] <= 1'b1;
              cons_read_data[owner[c]*DATA_BITS +: DATA_BITS] <=
                mem_read_data[c*DATA_BITS +: DATA_BITS];
              relay_write[c]           <= 1'b0;
              state[c]                 <= ST_RELAY;
            end else begin
              state[c] <= ST_READ_WAIT;
            end
          end
          ST_WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              mem_write_valid[c]         <= 1'b0;
              cons_write_ready[owner[c]] <= 1'b1;
              relay_write[c]             <= 1'b1;
              state[c]                   <= ST_RELAY;
            end else begin
              state[c] <= ST_WRITE_WAIT;
            end
          end
          ST_RELAY: begin
            // hold the response until the owner drops the matching valid
            if (relay_write[c] ? !cons_write_valid[owner[c]]
                               : !cons_read_valid[owner[c]]) begin
              cons_read_ready[owner[c]]  <= 1'b0;
              cons_write_ready[owner[c]] <= 1'b0;
              cons_read_data[owner[c]*DATA_BITS +: DATA_BITS] <= '0;
              owner[c] <= '0;
              state[c] <= ST_IDLE;
            end else begin
              state[c] <= ST_RELAY;
            end
          end
          default: begin
            state[c] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dcache_miss_arbiter.md
DCACHE_MISS_ARBITER -- requirements
Module: dcache_miss_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, number of dcache miss/eviction ports served.
REQ-004 SHALL have parameter NUM_CHANNELS, default 2, number of memory channels shared (1..NUM_CONSUMERS).
REQ-005 SHALL have ports, one per line:
  clk  input  1  clock, all state changes on rising edge
  reset  input  1  synchronous, active-high
  cons_read_valid  input  NUM_CONSUMERS  per-consumer read (fill) request
  cons_read_address  input  NUM_CONSUMERS*ADDR_BITS  read addresses, consumer i at slice i
  cons_read_ready  output  NUM_CONSUMERS  read complete, data valid
  cons_read_data  output  NUM_CONSUMERS*DATA_BITS  read data per consumer
  cons_write_valid  input  NUM_CONSUMERS  per-consumer write-back request
  cons_write_address  input  NUM_CONSUMERS*ADDR_BITS  write addresses
  cons_write_data  input  NUM_CONSUMERS*DATA_BITS  write data
  cons_write_ready  output  NUM_CONSUMERS  write complete
  mem_read_valid  output  NUM_CHANNELS  channel read request
  mem_read_address  output  NUM_CHANNELS*ADDR_BITS  channel read address
  mem_read_ready  input  NUM_CHANNELS  channel read data valid
  mem_read_data  input  NUM_CHANNELS*DATA_BITS  channel read data
  mem_write_valid  output  NUM_CHANNELS  channel write request
  mem_write_address  output  NUM_CHANNELS*ADDR_BITS  channel write address
  mem_write_data  output  NUM_CHANNELS*DATA_BITS  channel write data
  mem_write_ready  input  NUM_CHANNELS  channel write accepted

Function
REQ-006 Each channel SHALL run FSM: IDLE, READ_WAIT, WRITE_WAIT, RELAY; each channel records owning consumer index.
REQ-007 Consumer i SHALL be pending when (cons_read_valid[i] | cons_write_valid[i]), not owned by any channel, and its ready outputs are 0.
REQ-008 In one cycle, IDLE channels SHALL be scanned in ascending index; each claims the first unclaimed pending consumer found searching upward (wrapping) from rr_ptr; no consumer claimed by two channels.
REQ-009 After any grant, rr_ptr SHALL become (last granted index + 1) mod NUM_CONSUMERS; unchanged if no grant.
REQ-010 On grant with cons_write_valid[i]=1: next cycle mem_write_valid=1, address/data latched from consumer, state WRITE_WAIT; write takes priority when both valids high.
REQ-011 On grant with only cons_read_valid[i]=1: next cycle mem_read_valid=1, address latched, state READ_WAIT.
REQ-012 READ_WAIT with mem_read_ready=1: next cycle mem_read_valid=0, cons_read_ready[i]=1, cons_read_data[i]=mem_read_data captured, state RELAY.
REQ-013 WRITE_WAIT with mem_write_ready=1: next cycle mem_write_valid=0, cons_write_ready[i]=1, state RELAY.
REQ-014 RELAY SHALL hold ready/data until owning consumer drops the corresponding valid; then ready cleared next cycle and state IDLE.
REQ-015 Latency: consumer valid at edge N -> mem valid at N+1 (if channel free); mem ready at M -> consumer ready at M+1.
REQ-016 mem_*_address/data SHALL stay stable while mem_*_valid high; consumer valid dropped mid-wait SHALL NOT abort the memory transaction.
REQ-017 All consumers pending with all channels busy: requests SHALL wait without loss; no starvation under round-robin.

Reset
REQ-018 While reset=1 at clk edge: all outputs 0, all channels IDLE, owners cleared, rr_ptr=0.
REQ-019 Reset mid-transaction SHALL abandon in-flight requests; no ready pulses emitted afterward for them.

Configuration
REQ-020 Macro DCACHE_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-008/009.
REQ-021 Macro undefined: rr_ptr removed, search always starts at consumer 0 (fixed priority, lowest index wins); all other behaviour identical.

Verification
REQ-022 Single read: consumer 3 read addr 0x40, mem_read_ready after 2 cycles with data 0xA5 -> channel 0 mem_read_address=0x40, cons_read_ready[3]=1, cons_read_data[3]=0xA5, cleared 1 cycle after valid drops.
REQ-023 Single write: consumer 0 write 0x12<=0x7E -> mem_write_valid[0], address 0x12, data 0x7E; cons_write_ready[0] one cycle after mem_write_ready.
REQ-024 Contention: consumers 0,1,2 read same cycle, 2 channels -> ch0 owns 0, ch1 owns 1; consumer 2 granted first channel freed; rr_ptr=2 after first grant.
REQ-025 Fairness (RR_EN): all 8 consumers continuously re-request -> every consumer served within 4 grant rounds; macro off -> consumer 0 repeatedly served first.
REQ-026 Reset asserted during READ_WAIT -> next cycle all mem/cons valids and readies 0; late mem_read_ready produces no cons_read_ready.
REQ-027 Read+write both high on consumer 5 -> write issued first; read issued after RELAY completes and write valid drops.
